// File: rtl/uart_pkg.sv
// Shared UART constants and state encoding, used by the transmitter and the receiver.
package uart_pkg;

  // Oversampling ratio of s_tick relative to the baud rate.
  localparam int unsigned OVERSAMPLE = 16;
  // Tick index at the centre of a bit period.
  localparam int unsigned MID_SAMPLE = 7;

  // State encodings. Values 5..7 are unused and recover to idle.
  localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
  localparam logic [2:0] ST_START_ENC  = 3'd1;
  localparam logic [2:0] ST_DATA_ENC   = 3'd2;
  localparam logic [2:0] ST_PARITY_ENC = 3'd3;
  localparam logic [2:0] ST_STOP_ENC   = 3'd4;

  typedef enum logic [2:0] {
    StIdle   = ST_IDLE_ENC,
    StStart  = ST_START_ENC,
    StData   = ST_DATA_ENC,
    StParity = ST_PARITY_ENC,
    StStop   = ST_STOP_ENC
  } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle level (1).
module uart_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture; reset value matches an idle-high line.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_parity.sv
// UART receiver, 16x oversampled, with optional even-parity check.
// Define UART_RX_PARITY_EN to enable the parity bit and parity_err; otherwise
// frames are start + DBIT data + stop and parity_err is tied to 0.
module uart_rx_parity
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int unsigned TW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  logic              rx_s;
  uart_state_e       state_q, state_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [NW-1:0]     bit_q, bit_d;
  logic [DBIT-1:0]   shreg_q, shreg_d;
  logic [7:0]        dout_q, dout_d;
  logic              done_q, done_d;
  logic              ferr_q, ferr_d;
  // Set after a frame ends with the line low; blocks restart until rx returns high.
  logic              brk_q, brk_d;
`ifdef UART_RX_PARITY_EN
  logic              par_q, par_d;
  logic              perr_pend_q, perr_pend_d;
  logic              perr_q, perr_d;
`endif

  uart_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      tick_q      <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      dout_q      <= '0;
      done_q      <= 1'b0;
      ferr_q      <= 1'b0;
      brk_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q       <= 1'b0;
      perr_pend_q <= 1'b0;
      perr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      dout_q      <= dout_d;
      done_q      <= done_d;
      ferr_q      <= ferr_d;
      brk_q       <= brk_d;
`ifdef UART_RX_PARITY_EN
      par_q       <= par_d;
      perr_pend_q <= perr_pend_d;
      perr_q      <= perr_d;
`endif
    end
  end

  // Next-state logic: every counting state advances only on s_tick.
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    dout_d      = dout_q;
    done_d      = 1'b0;
    ferr_d      = ferr_q;
    brk_d       = brk_q;
`ifdef UART_RX_PARITY_EN
    par_d       = par_q;
    perr_pend_d = perr_pend_q;
    perr_d      = perr_q;
`endif
    case (state_q)
      StIdle: begin
        if (brk_q) begin
          if (rx_s) brk_d = 1'b0;
        end else if (!rx_s) begin
          state_d = StStart;
          tick_d  = '0;
        end
      end
      StStart: begin
        if (s_tick) begin
          if (tick_q == TW'(MID_SAMPLE)) begin
            if (!rx_s) begin
              state_d = StData;
              tick_d  = '0;
              bit_d   = '0;
`ifdef UART_RX_PARITY_EN
              par_d   = 1'b0;
`endif
            end else begin
              // Start bit did not hold to mid-bit: treat as a glitch.
              state_d = StIdle;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      StData: begin
        if (s_tick) begin
          if (tick_q == TW'(OVERSAMPLE - 1)) begin
            tick_d  = '0;
            shreg_d = {rx_s, shreg_q[DBIT-1:1]};
`ifdef UART_RX_PARITY_EN
            par_d   = par_q ^ rx_s;
`endif
            if (bit_q == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end else begin
              bit_d = bit_q + NW'(1);
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (s_tick) begin
          if (tick_q == TW'(OVERSAMPLE - 1)) begin
            tick_d      = '0;
            perr_pend_d = rx_s ^ par_q;
            state_d     = StStop;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
`endif
      StStop: begin
        if (s_tick) begin
          if (tick_q == TW'(SB_TICK - 1)) begin
            state_d           = StIdle;
            done_d            = 1'b1;
            ferr_d            = !rx_s;
            brk_d             = !rx_s;
            dout_d            = '0;
            dout_d[DBIT-1:0]  = shreg_q;
`ifdef UART_RX_PARITY_EN
            perr_d            = perr_pend_q;
`endif
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = perr_q;
`else
  assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_parity.sv
// Scoreboard bench for uart_rx_parity: frames are driven serially, expected
// results are queued at stimulus time and checked by a monitor on rx_done_tick.
module tb_uart_rx_parity;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
  localparam int unsigned FRAME_TICKS = 176;
`else
  localparam bit PAR_ON = 1'b0;
  localparam int unsigned FRAME_TICKS = 160;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       parity_err;
  logic       frame_err;

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;
  int unsigned tick_total = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned pulse_tick[$];

  uart_rx_parity #(
    .DBIT    (8),
    .SB_TICK (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .rx           (rx),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .parity_err   (parity_err),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  // s_tick strobe every 4th clock, updated 1 time unit after the edge.
  initial begin : tick_gen
    int tdiv;
    tdiv = 0;
    forever begin
      @(posedge clk);
      #1;
      tdiv = (tdiv + 1) % 4;
      s_tick = (tdiv == 0);
      if (s_tick) tick_total++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pop and compare on every completed frame.
  always @(negedge clk) begin
    if (rx_done_tick) begin
      exp_t e;
      pulses++;
      pulse_tick.push_back(tick_total);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse: actual dout=%0h required no pulse", dout);
      end else begin
        e = exp_q.pop_front();
        check("dout", 32'(dout), 32'(e.data));
        check("parity_err", 32'(parity_err), 32'(e.perr));
        check("frame_err", 32'(frame_err), 32'(e.ferr));
      end
    end
  end

  task automatic wait_ticks(input int n);
    int c;
    c = 0;
    while (c < n) begin
      @(posedge clk);
      if (s_tick) c++;
    end
    #2;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_ticks(16);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    if (PAR_ON) send_bit(par);
    send_bit(stop);
    rx = 1'b1;
  endtask

  task automatic push(input logic [7:0] data, input logic perr_if_par, input logic ferr);
    exp_t e;
    e.data = data;
    e.perr = PAR_ON ? perr_if_par : 1'b0;
    e.ferr = ferr;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(posedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin : stim
    int p0;
    int n0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_dout", 32'(dout), 32'h00);
    check("reset_done", 32'(rx_done_tick), 32'd0);
    check("reset_parity_err", 32'(parity_err), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    wait_ticks(20);

    // 0xA5: four ones, parity 0 is correct.
    push(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b1);
    drain("frame_a5");

    // 0x07: three ones, parity 0 is wrong.
    push(8'h07, 1'b1, 1'b0);
    send_frame(8'h07, 1'b0, 1'b1);
    drain("frame_07");

    // 0x3C with stop low, then a clean 0x55.
    push(8'h3C, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b0);
    wait_ticks(16);
    push(8'h55, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b1);
    drain("frame_55");

    // Short low glitch on an idle line.
    wait_ticks(8);
    p0 = pulses;
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(40);
    check("glitch_no_pulse", 32'(pulses), 32'(p0));
    check("glitch_dout", 32'(dout), 32'h55);

    // Reset in the middle of bit 3 of 0xFF.
    p0 = pulses;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    wait_ticks(8);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("abort_dout", 32'(dout), 32'h00);
    wait_ticks(40);
    check("abort_no_pulse", 32'(pulses), 32'(p0));
    push(8'h81, 1'b0, 1'b0);
    send_frame(8'h81, 1'b0, 1'b1);
    drain("frame_81");

    // Break: line held low well past one frame, then a clean 0xC3.
    wait_ticks(16);
    push(8'h00, 1'b0, 1'b1);
    rx = 1'b0;
    wait_ticks(int'(FRAME_TICKS) + 40);
    rx = 1'b1;
    wait_ticks(32);
    drain("frame_break");
    push(8'hC3, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b1);
    drain("frame_c3");

    // Back-to-back 0x12 (two ones, parity 0) and 0x34 (three ones, parity 1).
    wait_ticks(16);
    n0 = pulse_tick.size();
    push(8'h12, 1'b0, 1'b0);
    push(8'h34, 1'b0, 1'b0);
    send_frame(8'h12, 1'b0, 1'b1);
    send_frame(8'h34, 1'b1, 1'b1);
    drain("frame_b2b");
    check("b2b_pulse_count", 32'(pulse_tick.size() - n0), 32'd2);
    if (pulse_tick.size() >= n0 + 2)
      check("b2b_spacing", pulse_tick[n0+1] - pulse_tick[n0], 32'(FRAME_TICKS));

    wait_ticks(40);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_parity.md
UART_RX_PARITY -- requirements
Module: uart_rx_parity

Interface
REQ-001 The module SHALL have parameter DBIT, default 8, giving the number of data bits per frame, LSB first.
REQ-002 The module SHALL have parameter SB_TICK, default 16, giving the number of s_tick periods in the stop bit (16 = 1 stop bit).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port s_tick, input, 1 bit: a 1-cycle strobe at 16x the baud rate.
REQ-006 The module SHALL have port rx, input, 1 bit: the serial line, idle high, asynchronous to clk.
REQ-007 The module SHALL have port dout, output, 8 bits: the last received data byte, bit 0 first on the line.
REQ-008 The module SHALL have port rx_done_tick, output, 1 bit: a 1-cycle pulse when a frame completes.
REQ-009 The module SHALL have port parity_err, output, 1 bit: the parity mismatch flag for the last frame.
REQ-010 The module SHALL have port frame_err, output, 1 bit: the stop-bit-low flag for the last frame.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer before use, adding 2 clk cycles of latency.
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP, and unused encodings SHALL return to IDLE.
REQ-013 In IDLE, a low synchronized rx SHALL cause the FSM to enter START with the tick counter set to 0.
REQ-014 In START, at tick count 7 (mid-bit): if rx is low, the FSM SHALL go to DATA and clear the tick and bit counters; if rx is high, it SHALL treat the event as a glitch and return to IDLE with no pulse or flag change.
REQ-015 In DATA, at every 16th tick, the module SHALL shift rx into the data shift register MSB-first (so bit 0 is received first), XOR rx into the running parity, and after DBIT bits go to PARITY, or to STOP when parity is disabled.
REQ-016 In PARITY, at the 16th tick, the module SHALL sample rx as the parity bit and record a mismatch if the bit is not equal to the XOR of the data bits (even parity).
REQ-017 In STOP, at tick SB_TICK-1, the module SHALL sample rx, set frame_err if rx is low, load dout, update parity_err, pulse rx_done_tick for 1 cycle, and return to IDLE.
REQ-018 dout, parity_err and frame_err SHALL all update in the cycle of rx_done_tick and SHALL hold their values until the next rx_done_tick.
REQ-019 Tick counters SHALL advance only on s_tick, and the FSM SHALL ignore clk cycles without s_tick.
REQ-020 When DBIT < 8, the upper bits of dout SHALL be 0.
REQ-021 A frame SHALL still complete and pulse rx_done_tick when frame_err or parity_err is set.
REQ-022 Back-to-back frames SHALL be supported: IDLE SHALL accept a new start edge in the cycle after rx_done_tick.
REQ-023 A line held low (break) SHALL produce a frame with frame_err=1, after which the FSM SHALL wait in IDLE until rx goes high and then low again.

Reset
REQ-024 Asserting reset SHALL, on the next rising edge of clk, set state to IDLE, counters to 0, dout to 0x00, rx_done_tick, parity_err and frame_err to 0, and synchronizer flops to 1.
REQ-025 A reset asserted mid-frame SHALL abort the frame with no rx_done_tick pulse.

Configuration
REQ-026 The macro UART_RX_PARITY_EN, when defined, SHALL enable the PARITY state and the parity_err logic.
REQ-027 When UART_RX_PARITY_EN is undefined, the FSM SHALL go DATA->STOP directly, and parity_err SHALL be tied to 0 while the port remains present.

Structure
REQ-028 The state encoding localparams and the oversample constant (16) and mid-sample constant (7) SHALL live in the shared package uart_pkg, used by both the transmitter and the receiver.
REQ-029 The synchronizer SHALL be the sub-module uart_sync2, a 2-flop sync with reset value 1.

Verification
REQ-030 Bench scenario: with parity enabled, send 0xA5 with parity bit 0 and stop bit 1 -> one rx_done_tick, dout=0xA5, parity_err=0, frame_err=0.
REQ-031 Bench scenario: send 0x07 with parity bit 0 (wrong) -> dout=0x07, parity_err=1, frame_err=0.
REQ-032 Bench scenario: send 0x3C with the stop bit driven low -> dout=0x3C, frame_err=1; then a following valid 0x55 frame -> frame_err=0.
REQ-033 Bench scenario: a 4-tick low glitch on idle rx -> no rx_done_tick, FSM back in IDLE, and dout unchanged.
REQ-034 Bench scenario: assert reset during bit 3 of 0xFF, then send 0x81 -> no pulse for the aborted frame, then dout=0x81.
REQ-035 Bench scenario: build without UART_RX_PARITY_EN, send 0x12 and 0x34 back-to-back -> two pulses, 160 ticks apart, with parity_err=0.
